// File: rtl/fifo_push_arb.sv
// Round-robin arbiter feeding one registered beat per cycle into a FIFO push port.
// Define FIFO_ARB_BURST_EN to hold the grant on one requester until its req_last beat.
module fifo_push_arb #(
   parameter int NUM_REQ_IDX = 2,
   parameter int SIZE        = 4
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic [(2**NUM_REQ_IDX)-1:0]       req_val,
   output logic [(2**NUM_REQ_IDX)-1:0]       req_rdy,
   input  logic [(2**NUM_REQ_IDX)*SIZE-1:0]  req_data,
   input  logic [(2**NUM_REQ_IDX)-1:0]       req_last,
   output logic                              out_val,
   input  logic                              out_rdy,
   output logic [SIZE-1:0]                   out_data,
   output logic [NUM_REQ_IDX-1:0]            out_id
);

   localparam int NUM_REQ = 2**NUM_REQ_IDX;

   logic                   out_val_reg;
   logic [SIZE-1:0]        out_data_reg;
   logic [NUM_REQ_IDX-1:0] out_id_reg;
   logic [NUM_REQ_IDX-1:0] rr_ptr_reg;

   logic [SIZE-1:0]        beat [NUM_REQ];
   logic [NUM_REQ-1:0]     eligible;
   logic [NUM_REQ_IDX-1:0] cand;
   logic [NUM_REQ_IDX-1:0] grant_idx;
   logic                   grant_found;
   logic                   slot_free;
   logic                   accept;
   logic                   end_arb;

`ifdef FIFO_ARB_BURST_EN
   logic                   lock_reg;
   logic [NUM_REQ_IDX-1:0] lock_owner_reg;
`endif

   genvar gi;
   generate
      for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
         assign beat[gi] = req_data[gi*SIZE +: SIZE];
`ifdef FIFO_ARB_BURST_EN
         // an open burst makes every other requester ineligible, even if the owner idles
         assign eligible[gi] = req_val[gi] && (!lock_reg || (lock_owner_reg == NUM_REQ_IDX'(gi)));
`else
         assign eligible[gi] = req_val[gi];
`endif
         assign req_rdy[gi] = accept && (grant_idx == NUM_REQ_IDX'(gi));
      end
   endgenerate

   // Scan from the farthest offset down so the nearest eligible requester to rr_ptr wins.
   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      cand        = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         cand = rr_ptr_reg + NUM_REQ_IDX'(k);
         if (eligible[cand]) begin
            grant_found = 1'b1;
            grant_idx   = cand;
         end
      end
   end

   assign slot_free = !out_val_reg || out_rdy;
   assign accept    = grant_found && slot_free && !rst;

`ifdef FIFO_ARB_BURST_EN
   assign end_arb = accept && req_last[grant_idx];

   always_ff @(posedge clk) begin
      if (rst) begin
         lock_reg       <= 1'b0;
         lock_owner_reg <= '0;
      end else if (accept) begin
         lock_reg       <= !req_last[grant_idx];
         lock_owner_reg <= grant_idx;
      end
   end
`else
   logic unused_last;
   assign unused_last = ^req_last;
   assign end_arb     = accept;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         out_val_reg  <= 1'b0;
         out_data_reg <= '0;
         out_id_reg   <= '0;
         rr_ptr_reg   <= '0;
      end else begin
         if (accept) begin
            out_val_reg  <= 1'b1;
            out_data_reg <= beat[grant_idx];
            out_id_reg   <= grant_idx;
         end else if (out_rdy) begin
            out_val_reg  <= 1'b0;
         end
         if (end_arb) begin
            rr_ptr_reg <= grant_idx + NUM_REQ_IDX'(1);
         end
      end
   end

   assign out_val  = out_val_reg;
   assign out_data = out_data_reg;
   assign out_id   = out_id_reg;

endmodule

// File: tb/tb_fifo_push_arb.sv
// Self-checking bench for fifo_push_arb: directed scenarios plus randomized traffic vs a reference model.
module tb_fifo_push_arb;

   localparam int IDX  = 2;
   localparam int N    = 4;
   localparam int SIZE = 4;

   logic              clk = 1'b0;
   logic              rst;
   logic [N-1:0]      req_val;
   logic [N-1:0]      req_rdy;
   logic [N*SIZE-1:0] req_data;
   logic [N-1:0]      req_last;
   logic              out_val;
   logic              out_rdy;
   logic [SIZE-1:0]   out_data;
   logic [IDX-1:0]    out_id;

   int checks = 0;
   int errors = 0;

   // reference model: slot contents, round-robin pointer, burst ownership
   int              m_rr;
   bit              m_locked;
   int              m_owner;
   bit              m_val;
   logic [SIZE-1:0] m_data;
   int              m_id;

   fifo_push_arb #(.NUM_REQ_IDX(IDX), .SIZE(SIZE)) dut (
      .clk      (clk),
      .rst      (rst),
      .req_val  (req_val),
      .req_rdy  (req_rdy),
      .req_data (req_data),
      .req_last (req_last),
      .out_val  (out_val),
      .out_rdy  (out_rdy),
      .out_data (out_data),
      .out_id   (out_id)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   // Which requester the rules say is served right now (one-hot, 0 if none).
   function automatic logic [N-1:0] model_rdy();
      logic [N-1:0] r;
      int c;
      r = '0;
      if (rst) return r;
      if (m_val && !out_rdy) return r;
      for (int k = 0; k < N; k++) begin
         c = (m_rr + k) % N;
         if (m_locked && c != m_owner) continue;
         if (req_val[c]) begin
            r[c] = 1'b1;
            return r;
         end
      end
      return r;
   endfunction

   task automatic model_step();
      logic [N-1:0] g;
      int c;
      g = model_rdy();
      c = -1;
      for (int k = 0; k < N; k++) if (g[k]) c = k;
      if (rst) begin
         m_rr = 0; m_locked = 0; m_owner = 0; m_val = 0; m_data = '0; m_id = 0;
      end else if (c >= 0) begin
         m_val  = 1;
         m_data = req_data[c*SIZE +: SIZE];
         m_id   = c;
`ifdef FIFO_ARB_BURST_EN
         if (req_last[c]) begin
            m_locked = 0;
            m_rr     = (c + 1) % N;
         end else begin
            m_locked = 1;
            m_owner  = c;
         end
`else
         m_rr = (c + 1) % N;
`endif
      end else if (out_rdy) begin
         m_val = 0;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic do_reset();
      rst = 1; req_val = '0; req_last = '0; req_data = '0; out_rdy = 0;
      tick();
      tick();
      rst = 0;
   endtask

   task automatic test_reset();
      rst = 1; req_val = 4'b1111; req_last = 4'b1111; req_data = 16'h3210; out_rdy = 1;
      #3;
      checks++;
      if (req_rdy !== 4'b0000) begin errors++; $display("FAIL reset_rdy_in_rst: got %b expected 0000", req_rdy); end
      tick();
      tick();
      checks++;
      if (out_val !== 1'b0) begin errors++; $display("FAIL reset_out_val: got %b expected 0", out_val); end
      checks++;
      if (out_data !== 4'h0) begin errors++; $display("FAIL reset_out_data: got %h expected 0", out_data); end
      checks++;
      if (out_id !== 2'd0) begin errors++; $display("FAIL reset_out_id: got %0d expected 0", out_id); end
      rst = 0; req_val = 4'b0000;
      #3;
      checks++;
      if (req_rdy !== 4'b0000) begin errors++; $display("FAIL reset_idle_rdy: got %b expected 0000", req_rdy); end
      tick();
      checks++;
      if (out_val !== 1'b0) begin errors++; $display("FAIL reset_idle_val: got %b expected 0", out_val); end
      req_val = 4'b1111;
      #3;
      checks++;
      if (req_rdy !== 4'b0001) begin errors++; $display("FAIL reset_rr_start: got %b expected 0001", req_rdy); end
      tick();
      req_val = '0;
      tick();
      $display("test_reset done");
   endtask

   task automatic test_round_robin();
      logic [N-1:0] exp_rdy;
      do_reset();
      req_val = 4'b1111; req_last = 4'b1111; req_data = 16'h3210; out_rdy = 1;
      for (int i = 0; i < 5; i++) begin
         exp_rdy = '0;
         exp_rdy[i % N] = 1'b1;
         #3;
         checks++;
         if (req_rdy !== exp_rdy) begin errors++; $display("FAIL rr_rdy[%0d]: got %b expected %b", i, req_rdy, exp_rdy); end
         tick();
         checks++;
         if (out_val !== 1'b1 || out_id !== IDX'(i % N) || out_data !== SIZE'(i % N)) begin
            errors++;
            $display("FAIL rr_out[%0d]: got val=%b id=%0d data=%h expected val=1 id=%0d data=%h",
                     i, out_val, out_id, out_data, i % N, i % N);
         end
         $display("rr beat %0d: id %0d data %h", i, out_id, out_data);
      end
      req_val = '0;
      tick();
      checks++;
      if (out_val !== 1'b0) begin errors++; $display("FAIL rr_drain: got %b expected 0", out_val); end
   endtask

   task automatic test_stall();
      do_reset();
      req_val = 4'b0100; req_last = 4'b1111; req_data = 16'h0500; out_rdy = 0;
      #3;
      checks++;
      if (req_rdy !== 4'b0100) begin errors++; $display("FAIL stall_first_rdy: got %b expected 0100", req_rdy); end
      tick();
      checks++;
      if (out_val !== 1'b1 || out_data !== 4'h5 || out_id !== 2'd2) begin
         errors++; $display("FAIL stall_load: got val=%b data=%h id=%0d expected 1/5/2", out_val, out_data, out_id);
      end
      req_data = 16'h0600;
      for (int i = 0; i < 3; i++) begin
         #3;
         checks++;
         if (req_rdy !== 4'b0000) begin errors++; $display("FAIL stall_rdy[%0d]: got %b expected 0000", i, req_rdy); end
         tick();
         checks++;
         if (out_val !== 1'b1 || out_data !== 4'h5 || out_id !== 2'd2) begin
            errors++; $display("FAIL stall_hold[%0d]: got val=%b data=%h id=%0d expected 1/5/2", i, out_val, out_data, out_id);
         end
         $display("stall cycle %0d: holding id %0d data %h", i, out_id, out_data);
      end
      out_rdy = 1;
      #3;
      checks++;
      if (req_rdy !== 4'b0100) begin errors++; $display("FAIL stall_pop_accept: got %b expected 0100", req_rdy); end
      tick();
      checks++;
      if (out_val !== 1'b1 || out_data !== 4'h6 || out_id !== 2'd2) begin
         errors++; $display("FAIL stall_next: got val=%b data=%h id=%0d expected 1/6/2", out_val, out_data, out_id);
      end
      req_val = '0;
      tick();
      checks++;
      if (out_val !== 1'b0) begin errors++; $display("FAIL stall_fall: got %b expected 0", out_val); end
   endtask

   task automatic test_wrap();
      do_reset();
      req_val = 4'b0100; req_last = 4'b1111; req_data = 16'h0200; out_rdy = 1;
      tick();
      req_val = 4'b1001; req_data = 16'h3000;
      #3;
      checks++;
      if (req_rdy !== 4'b1000) begin errors++; $display("FAIL wrap_rdy3: got %b expected 1000", req_rdy); end
      tick();
      checks++;
      if (out_id !== 2'd3 || out_data !== 4'h3) begin errors++; $display("FAIL wrap_id3: got id=%0d data=%h expected 3/3", out_id, out_data); end
      #3;
      checks++;
      if (req_rdy !== 4'b0001) begin errors++; $display("FAIL wrap_rdy0: got %b expected 0001", req_rdy); end
      tick();
      checks++;
      if (out_id !== 2'd0 || out_data !== 4'h0) begin errors++; $display("FAIL wrap_id0: got id=%0d data=%h expected 0/0", out_id, out_data); end
      $display("wrap: grants 3 then 0");
      req_val = '0;
      tick();
   endtask

   task automatic test_burst();
      int exp_ids[5];
      int n;
      int b1;
      int k1;
      logic [N-1:0] exp_rdy;
      logic [SIZE-1:0] exp_data;
`ifdef FIFO_ARB_BURST_EN
      exp_ids = '{1, 1, 1, 2, 0};
      n = 4;
`else
      exp_ids = '{1, 2, 1, 2, 1};
      n = 5;
`endif
      do_reset();
      out_rdy = 1; b1 = 0; k1 = 0;
      for (int i = 0; i < n; i++) begin
         req_val = '0; req_last = '0; req_data = '0;
         req_val[2]  = 1'b1;
         req_last[2] = 1'b1;
         req_data[2*SIZE +: SIZE] = 4'hA;
         req_val[1]  = (b1 < 3);
         req_last[1] = (b1 == 2);
         req_data[1*SIZE +: SIZE] = SIZE'(b1 + 1);
         exp_rdy = '0;
         exp_rdy[exp_ids[i]] = 1'b1;
         #3;
         checks++;
         if (req_rdy !== exp_rdy) begin errors++; $display("FAIL burst_rdy[%0d]: got %b expected %b", i, req_rdy, exp_rdy); end
         if (req_rdy[1]) b1++;
         tick();
         if (exp_ids[i] == 1) begin
            k1++;
            exp_data = SIZE'(k1);
         end else begin
            exp_data = 4'hA;
         end
         checks++;
         if (out_id !== IDX'(exp_ids[i]) || out_data !== exp_data) begin
            errors++; $display("FAIL burst_out[%0d]: got id=%0d data=%h expected id=%0d data=%h", i, out_id, out_data, exp_ids[i], exp_data);
         end
         $display("burst beat %0d: id %0d data %h", i, out_id, out_data);
      end
      req_val = '0;
      tick();
   endtask

   task automatic test_reset_mid();
      do_reset();
      req_val = 4'b0010; req_last = 4'b0000; req_data = 16'h0070; out_rdy = 0;
      tick();
      checks++;
      if (out_val !== 1'b1) begin errors++; $display("FAIL midrst_load: got %b expected 1", out_val); end
      rst = 1; req_val = 4'b1111;
      #3;
      checks++;
      if (req_rdy !== 4'b0000) begin errors++; $display("FAIL midrst_rdy: got %b expected 0000", req_rdy); end
      tick();
      checks++;
      if (out_val !== 1'b0 || out_id !== 2'd0 || out_data !== 4'h0) begin
         errors++; $display("FAIL midrst_clear: got val=%b id=%0d data=%h expected 0/0/0", out_val, out_id, out_data);
      end
      rst = 0; req_last = 4'b1111; out_rdy = 1;
      #3;
      checks++;
      if (req_rdy !== 4'b0001) begin errors++; $display("FAIL midrst_restart: got %b expected 0001", req_rdy); end
      tick();
      checks++;
      if (out_val !== 1'b1 || out_id !== 2'd0) begin errors++; $display("FAIL midrst_first: got val=%b id=%0d expected 1/0", out_val, out_id); end
      $display("reset mid-burst: restart at requester %0d", out_id);
      req_val = '0;
      tick();
   endtask

   task automatic test_random();
      logic [N-1:0] exp_rdy;
      do_reset();
      for (int cyc = 0; cyc < 400; cyc++) begin
         rst      = ($urandom_range(0, 49) == 0);
         req_val  = N'($urandom);
         req_last = N'($urandom);
         req_data = (N*SIZE)'($urandom);
         out_rdy  = ($urandom_range(0, 3) != 0);
         #3;
         exp_rdy = model_rdy();
         checks++;
         if (req_rdy !== exp_rdy) begin errors++; $display("FAIL rand_rdy@%0d: got %b expected %b", cyc, req_rdy, exp_rdy); end
         if (exp_rdy != '0) $display("rand cycle %0d: accept rdy %b", cyc, exp_rdy);
         tick();
         checks++;
         if (out_val !== m_val) begin errors++; $display("FAIL rand_val@%0d: got %b expected %b", cyc, out_val, m_val); end
         if (m_val) begin
            checks++;
            if (out_data !== m_data || out_id !== IDX'(m_id)) begin
               errors++; $display("FAIL rand_out@%0d: got id=%0d data=%h expected id=%0d data=%h", cyc, out_id, out_data, m_id, m_data);
            end
         end
      end
      rst = 0; req_val = '0;
      tick();
   endtask

   initial begin
      test_reset();
      test_round_robin();
      test_stall();
      test_wrap();
      test_burst();
      test_reset_mid();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
